// File: rtl/stream_master_decim_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_master_decim_pkg                                                  |
// | Shared types and default geometry for the FIR decimating stream master.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package stream_master_decim_pkg;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_NUM_CH   = 2;
    localparam int DEF_RATE_W   = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_QUOTA    = 2;
    localparam int BEAT_W       = DEF_NUM_CH * DEF_SAMPLE_W;

    // Configuration value held in rate_q out of reset (pass-through).
    localparam logic [DEF_RATE_W-1:0] FIR_DOWN_RATE = '0;

    typedef logic [DEF_SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              last;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/stream_master_decim_axis_out_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_master_decim_axis_out_fifo                                        |
// | Output FIFO with a registered head word; no write-to-read bypass.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stream_master_decim_axis_out_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       M_AXIS_ACLK,
    input  logic                       M_AXIS_ARESETN,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count_next
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] head_next;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);
    assign rd_next = rd_ptr + AW'(do_pop);

    assign count_next = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

    // The head register is reloaded every cycle; a word written into the slot
    // becoming the head is forwarded so it shows up exactly one cycle later.
    assign head_next = (do_push && (wr_ptr == rd_next)) ? wr_data : mem[rd_next];

    always_ff @(posedge M_AXIS_ACLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_next;
            count_q <= count_next;
            head    <= head_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_master_decim.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_master_decim                                                      |
// | Decimating AXI4-Stream master with credit-style is_ready and overflow.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stream_master_decim
    import stream_master_decim_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int RATE_W   = DEF_RATE_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int QUOTA    = DEF_QUOTA
) (
    input  logic                           M_AXIS_ACLK,
    input  logic                           M_AXIS_ARESETN,
    input  logic                           in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]     in_data,
    input  logic                           in_last,
    input  logic [RATE_W-1:0]              rate,
    input  logic [RATE_W-1:0]              phase,
    output logic                           is_ready,
    output logic                           overflow,
    input  logic                           overflow_clr,
    output logic                           M_AXIS_TVALID,
    output logic [NUM_CH*SAMPLE_W-1:0]     M_AXIS_TDATA,
    output logic [NUM_CH*SAMPLE_W/8-1:0]   M_AXIS_TSTRB,
    output logic                           M_AXIS_TLAST,
    input  logic                           M_AXIS_TREADY
);

    localparam int DATA_W = NUM_CH * SAMPLE_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              at_start;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] phase_q;
    logic [RATE_W-1:0] cnt;
    logic [RATE_W-1:0] rate_eff;
    logic [RATE_W-1:0] phase_raw;
    logic [RATE_W-1:0] phase_eff;
    logic              keep;
    logic              push_req;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  free_next;

    // At a frame boundary the live controls apply to the very first beat.
    assign rate_eff  = at_start ? rate  : rate_q;
    assign phase_raw = at_start ? phase : phase_q;
    assign phase_eff = (phase_raw > rate_eff) ? rate_eff : phase_raw;

    assign keep     = (cnt == phase_eff) | in_last;
    assign push_req = in_valid & keep;
    assign pop      = M_AXIS_TVALID & M_AXIS_TREADY;
    assign drop     = push_req & fifo_full & ~pop;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            at_start <= 1'b1;
            rate_q   <= RATE_W'(FIR_DOWN_RATE);
            phase_q  <= '0;
            cnt      <= '0;
        end else if (in_valid) begin
            if (at_start) begin
                rate_q  <= rate_eff;
                phase_q <= phase_eff;
            end
            at_start <= in_last;
            if (in_last || (cnt == rate_eff)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + RATE_W'(1);
            end
        end
    end

    // A fresh drop wins over a clear in the same cycle.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    assign free_next = CNT_W'(DEPTH) - count_next;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            is_ready <= 1'b0;
        end else begin
            is_ready <= (free_next > CNT_W'(QUOTA));
        end
    end

    stream_master_decim_axis_out_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .M_AXIS_ACLK    (M_AXIS_ACLK),
        .M_AXIS_ARESETN (M_AXIS_ARESETN),
        .wr_en          (push_req),
        .wr_data        ({in_data, in_last}),
        .rd_en          (M_AXIS_TREADY),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .head           (fifo_head),
        .count_next     (count_next)
    );

    assign M_AXIS_TVALID = ~fifo_empty;
    assign M_AXIS_TDATA  = fifo_head[DATA_W:1];
    assign M_AXIS_TLAST  = fifo_head[0];
    assign M_AXIS_TSTRB  = '1;

endmodule
`default_nettype wire

// File: tb/tb_stream_master_decim.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stream_master_decim                                                   |
// | Scoreboard bench for the decimating stream master.                       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_stream_master_decim;
    import stream_master_decim_pkg::*;

    localparam int BW = DEF_NUM_CH * DEF_SAMPLE_W;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  in_valid = 1'b0;
    logic [BW-1:0]         in_data = '0;
    logic                  in_last = 1'b0;
    logic [DEF_RATE_W-1:0] rate = '0;
    logic [DEF_RATE_W-1:0] phase = '0;
    logic                  is_ready;
    logic                  overflow;
    logic                  overflow_clr = 1'b0;
    logic                  tvalid;
    logic [BW-1:0]         tdata;
    logic [BW/8-1:0]       tstrb;
    logic                  tlast;
    logic                  tready = 1'b1;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    logic  rdy_d1 = 1'b0;
    logic  rdy_d2 = 1'b0;

    always #5 clk = ~clk;

    stream_master_decim dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rstn),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .rate           (rate),
        .phase          (phase),
        .is_ready       (is_ready),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TSTRB   (tstrb),
        .M_AXIS_TLAST   (tlast),
        .M_AXIS_TREADY  (tready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int tag, input int i);
        logic [15:0] lo;
        lo = 16'(tag * 256 + i);
        return {lo ^ 16'h8000, lo};
    endfunction

    // One beat for one cycle; called and returns at posedge + 1.
    task automatic send(input int tag, input int i, input bit last, input bit kept);
        in_valid = 1'b1;
        in_data  = mk(tag, i);
        in_last  = last;
        if (kept) exp_q.push_back('{data: mk(tag, i), last: last});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pop the scoreboard on every AXIS handshake.
    always @(negedge clk) begin
        if (rstn && tvalid && tready) begin : mon
            beat_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=%0h required=none", tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 64'(tdata), 64'(e.data));
                check("beat_last", 64'(tlast), 64'(e.last));
            end
        end
    end

    // Upstream view of is_ready delayed two cycles, modelling a QUOTA-deep pipe.
    always @(negedge clk) begin
        rdy_d2 = rdy_d1;
        rdy_d1 = is_ready;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] m2;
        logic [4:0]  m3;
        logic [3:0]  m3b;
        logic [3:0]  m6;
        m2  = 12'hC44;     // beats 2,6,10,11
        m3  = 5'b10001;    // beats 0,4
        m3b = 4'b1101;     // beats 0,2,3 with rate 1
        m6  = 4'b1010;     // beats 1,3 with rate 3 phase 1

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_is_ready", 64'(is_ready), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("tstrb", 64'(tstrb), 64'hF);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("is_ready_after_rst", 64'(is_ready), 64'd1);

        // Pass-through, 10 beats, last on the 10th.
        rate = 0; phase = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) check("pre_tvalid", 64'(tvalid), 64'd0);
            send(1, i, i == 9, 1'b1);
            if (i == 0) check("latency_tvalid", 64'(tvalid), 64'd1);
        end
        wait_drain("drain_t1");

        // rate 3 phase 2, 12-beat frame.
        rate = 3; phase = 2;
        for (int i = 0; i < 12; i++) send(2, i, i == 11, m2[i]);
        wait_drain("drain_t2");

        // Mid-frame rate change is ignored until the next frame.
        rate = 3; phase = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) rate = 1;
            send(3, i, i == 4, m3[i]);
        end
        for (int i = 0; i < 4; i++) send(4, i, i == 3, m3b[i]);
        wait_drain("drain_t3");

        // Upstream honours is_ready with a two-cycle lag while TREADY is low.
        rate = 0; phase = 0;
        tready = 1'b0;
        fork
            begin
                repeat (15) @(posedge clk);
                #1;
                check("credit_stall_is_ready", 64'(is_ready), 64'd0);
                repeat (5) @(posedge clk);
                #1;
                tready = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++) begin : issue
                    int w;
                    w = 0;
                    while (!rdy_d2 && w < 200) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    if (w >= 200) check("credit_wait_timeout", 64'd1, 64'd0);
                    send(5, i, i == 11, 1'b1);
                end
            end
        join
        wait_drain("drain_t4");
        check("credit_no_overflow", 64'(overflow), 64'd0);

        // Upstream ignores is_ready: last two beats are dropped.
        tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            overflow_clr = (i == 9);
            send(6, i, i == 9, i < 8);
            overflow_clr = 1'b0;
            if (i == 7) check("ovf_before_full", 64'(overflow), 64'd0);
            if (i == 8) check("ovf_on_drop", 64'(overflow), 64'd1);
        end
        check("ovf_clr_vs_drop", 64'(overflow), 64'd1);
        check("ovf_full_tvalid", 64'(tvalid), 64'd1);
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);
        tready = 1'b1;
        wait_drain("drain_t5");

        // Reset mid-frame with the FIFO partly filled.
        tready = 1'b0;
        rate = 1; phase = 0;
        for (int i = 0; i < 9; i++) send(7, i, 1'b0, 1'b0);
        check("pre_reset_tvalid", 64'(tvalid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_tvalid", 64'(tvalid), 64'd0);
        check("async_rst_tdata", 64'(tdata), 64'd0);
        check("async_rst_is_ready", 64'(is_ready), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_is_ready", 64'(is_ready), 64'd1);
        check("post_rst_tvalid", 64'(tvalid), 64'd0);
        tready = 1'b1;
        rate = 3; phase = 1;
        for (int i = 0; i < 4; i++) send(8, i, i == 3, m6[i]);
        wait_drain("drain_t6");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
